// File: rtl/md_unit_param.sv
`timescale 1ns/1ps
// Multiply/divide unit with HI/LO registers for the Execute stage.
// Multiply, multiply-accumulate/subtract and divide complete after a fixed, parameterised latency.
module md_unit_param #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HIwrite,
  input  logic             LOwrite,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned DW      = 2 * WIDTH;
  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_d;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               launch;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [DW-1:0]      acc_q;

  logic               is_div, is_signed, div_zero;
  logic [DW-1:0]      ext_a, ext_b, prod, mac;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b, quot_mag, rem_mag, quot, rem;

  // Result datapath, evaluated from the operands latched at launch
  always_comb begin
    is_div    = (op_q[2:1] == 2'b01);
    is_signed = op_q[0];
    ext_a     = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b     = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod      = ext_a * ext_b;
    if (op_q[2]) mac = op_q[1] ? (acc_q - prod) : (acc_q + prod);
    else         mac = prod;

    // Sign-magnitude division keeps most-negative / -1 well defined
    a_neg    = is_signed & a_q[WIDTH-1];
    b_neg    = is_signed & b_q[WIDTH-1];
    mag_a    = a_neg ? (-a_q) : a_q;
    mag_b    = b_neg ? (-b_q) : b_q;
    div_zero = (b_q == '0);
    quot_mag = div_zero ? '0 : (mag_a / mag_b);
    rem_mag  = div_zero ? '0 : (mag_a % mag_b);
    quot     = (a_neg ^ b_neg) ? (-quot_mag) : quot_mag;
    rem      = a_neg ? (-rem_mag) : rem_mag;
  end

  // Next-state, counter and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy;
    hi_d    = HI;
    lo_d    = LO;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          launch = 1'b1;
        end else begin
          if (HIwrite) hi_d = A;
          if (LOwrite) lo_d = A;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (is_div) begin
            if (!div_zero) begin
              hi_d = rem;
              lo_d = quot;
            end
          end else begin
            {hi_d, lo_d} = mac;
          end
          if (start) launch = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d = RUN;
      busy_d  = 1'b1;
      cnt_d   = (MDop[2:1] == 2'b01) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end
  end

  // A back-to-back accumulate sees the result completing on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      HI      <= hi_d;
      LO      <= lo_d;
      if (launch) begin
        op_q  <= MDop;
        a_q   <= A;
        b_q   <= B;
        acc_q <= {hi_d, lo_d};
      end
    end
  end

endmodule

// File: tb/tb_md_unit_param.sv
`timescale 1ns/1ps
// Scoreboard bench for md_unit_param: expected HI/LO and busy latency queued at launch,
// compared by a monitor when the operation completes.
module tb_md_unit_param;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start1, start2;
  logic [2:0]  mdop;
  logic [31:0] a, b;
  logic [15:0] a16, b16;
  logic        hi_we, lo_we;
  logic        busy, busy1, busy2;
  logic [31:0] hi, lo, hi1, lo1;
  logic [15:0] hi2, lo2;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  exp_t e;
  int   cyc = 0;

  always #5 clk = ~clk;

  md_unit_param u_dut (
    .clk(clk), .reset(reset), .start(start), .MDop(mdop), .A(a), .B(b),
    .HIwrite(hi_we), .LOwrite(lo_we), .busy(busy), .HI(hi), .LO(lo)
  );

  md_unit_param #(.MULT_CYCLES(1)) u_dut_fast (
    .clk(clk), .reset(reset), .start(start1), .MDop(mdop), .A(a), .B(b),
    .HIwrite(1'b0), .LOwrite(1'b0), .busy(busy1), .HI(hi1), .LO(lo1)
  );

  md_unit_param #(.WIDTH(16)) u_dut_w16 (
    .clk(clk), .reset(reset), .start(start2), .MDop(mdop), .A(a16), .B(b16),
    .HIwrite(1'b0), .LOwrite(1'b0), .busy(busy2), .HI(hi2), .LO(lo2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Completion monitor: count busy cycles of the oldest op, compare when it retires
  always @(negedge clk) begin
    if (reset || q.size() == 0) begin
      cyc = 0;
    end else if (cyc == q[0].cycles) begin
      e = q.pop_front();
      check("hi", 64'(hi), 64'(e.hi));
      check("lo", 64'(lo), 64'(e.lo));
      check("busy_after", 64'(busy), 64'(q.size() != 0));
      cyc = busy ? 1 : 0;
    end else if (busy) begin
      cyc++;
    end else if (cyc != 0) begin
      e = q.pop_front();
      check("busy_short", 64'(cyc), 64'(e.cycles));
      cyc = 0;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] ehi, input logic [31:0] elo, input int ncyc);
    exp_t x;
    @(negedge clk);
    start = 1'b1; mdop = op; a = aa; b = bb;
    x.hi = ehi; x.lo = elo; x.cycles = ncyc;
    q.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      check("timeout", 64'(q.size()), 64'(0));
      q.delete();
    end
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [31:0] v);
    @(negedge clk);
    hi_we = hw; lo_we = lw; a = v;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; start1 = 1'b0; start2 = 1'b0; mdop = 3'd0;
    a = '0; b = '0; a16 = '0; b16 = '0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));

    // Basic multiply and divides
    issue(3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    wait_idle();
    issue(3'b010, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    wait_idle();
    issue(3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    wait_idle();
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
    wait_idle();

    // Divide by zero leaves HI/LO untouched
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    check("mthi", 64'(hi), 64'h11);
    check("mtlo", 64'(lo), 64'h22);
    issue(3'b010, 32'd5, 32'd0, 32'h11, 32'h22, 10);
    wait_idle();

    // Accumulate and subtract
    mt(1'b0, 1'b1, 32'd10);
    mt(1'b1, 1'b0, 32'd0);
    issue(3'b100, 32'd4, 32'd5, 32'd0, 32'd30, 5);
    wait_idle();
    issue(3'b111, 32'd1, 32'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    wait_idle();

    // Start while busy is ignored
    issue(3'b000, 32'd6, 32'd7, 32'd0, 32'd42, 5);
    @(negedge clk);
    start = 1'b1; mdop = 3'b010; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("ign_start_busy", 64'(busy), 64'(0));
    check("ign_start_lo", 64'(lo), 64'd42);

    // HIwrite while busy is ignored
    issue(3'b000, 32'd2, 32'd3, 32'd0, 32'd6, 5);
    hi_we = 1'b1; a = 32'h55;
    @(negedge clk);
    hi_we = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("ign_hiw", 64'(hi), 64'd0);

    // Start at the completion edge: accepted, busy continuous
    issue(3'b000, 32'd3, 32'd3, 32'd0, 32'd9, 5);
    repeat (3) @(negedge clk);
    issue(3'b010, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    wait_idle();

    // Random multiplies and divides against a 64-bit reference
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] ra, rb;
      logic [63:0] r;
      longint      sa, sb;
      op = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i[0]) rb = rb & 32'hFF;
      if (rb == 32'd0) rb = 32'd1;
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      case (op)
        3'd0:    r = {32'd0, ra} * {32'd0, rb};
        3'd1:    r = 64'(sa * sb);
        3'd2:    r = {ra % rb, ra / rb};
        default: r = {32'(sa % sb), 32'(sa / sb)};
      endcase
      issue(op, ra, rb, r[63:32], r[31:0], op[1] ? 10 : 5);
      wait_idle();
    end

    // Single-cycle multiply variant
    @(negedge clk);
    start1 = 1'b1; mdop = 3'b001; a = 32'hFFFF_FFFE; b = 32'd3;
    @(negedge clk);
    start1 = 1'b0;
    check("fast_busy1", 64'(busy1), 64'(1));
    @(negedge clk);
    check("fast_busy0", 64'(busy1), 64'(0));
    check("fast_hi", 64'(hi1), 64'hFFFF_FFFF);
    check("fast_lo", 64'(lo1), 64'hFFFF_FFFA);

    // 16-bit variant, unsigned
    @(negedge clk);
    start2 = 1'b1; mdop = 3'b000; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(negedge clk);
    start2 = 1'b0;
    repeat (4) @(negedge clk);
    check("w16_busy", 64'(busy2), 64'(1));
    @(negedge clk);
    check("w16_done", 64'(busy2), 64'(0));
    check("w16_hi", 64'(hi2), 64'hFFFE);
    check("w16_lo", 64'(lo2), 64'h0001);

    // Asynchronous reset in the middle of a multiply
    mt(1'b1, 1'b1, 32'h5A);
    issue(3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    repeat (2) @(negedge clk);
    q.delete();
    #1 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_hi", 64'(hi), 64'(0));
    check("arst_lo", 64'(lo), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("arst_busy_late", 64'(busy), 64'(0));
    check("arst_hi_late", 64'(hi), 64'(0));
    check("arst_lo_late", 64'(lo), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
Parametrised multiply/divide unit with HI/LO registers, sitting in the Execute stage beside the ALU. It is driven by the controller's start, MDop, HIwrite and LOwrite signals. It generalises the fixed mult/div block with configurable operand width, configurable latencies, and multiply-accumulate/subtract modes. The busy output feeds the hazard unit, which stalls any MD-class instruction in D while start or busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width in bits.
MULT_CYCLES, 5, latency of multiply-class ops in cycles; legal range is 1 or more.
DIV_CYCLES, 10, latency of divide-class ops in cycles; legal range is 1 or more.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  launch the operation selected by MDop, using A and B.
MDop  input  3  000 multu, 001 mult, 010 divu, 011 div, 100 maddu, 101 madd, 110 msubu, 111 msub.
A  input  WIDTH  rs operand.
B  input  WIDTH  rt operand.
HIwrite  input  1  mthi: HI <= A.
LOwrite  input  1  mtlo: LO <= A.
busy  output  1  an operation is in flight.
HI  output  WIDTH  HI register.
LO  output  WIDTH  LO register.

Behaviour:
- Reset (async, active-high): HI=0, LO=0, busy=0, counter=0, state IDLE. Reset mid-operation discards the operation and does not update HI or LO.
- States:
  - IDLE to RUN when start=1 and busy=0.
  - RUN to IDLE when the counter reaches 1.
- Launch (start=1 in IDLE):
  - Latch A, B, MDop and the current {HI,LO} for accumulate ops.
  - Load counter with MULT_CYCLES (MDop != 01x) or DIV_CYCLES (MDop = 01x).
- Timing: start sampled at edge 0.
  - busy=1 for exactly N cycles after edge 0.
  - HI/LO take the result at edge N; the new values are visible and busy=0 from edge N onward.
  - A back-to-back start is accepted at edge N.
  - start is accepted only when busy=0; start while busy=1 is ignored.
- Multiply:
  - The 2*WIDTH-bit product is split {HI,LO}, HI upper.
  - multu/maddu/msubu treat operands as unsigned; mult/madd/msub as two's complement.
- Accumulate: {HI,LO} = latched {HI,LO} ± product, modulo 2^(2*WIDTH). There is no overflow flag.
- Divide:
  - LO = quotient truncated toward zero; HI = remainder, whose sign follows the dividend.
  - B=0: HI/LO unchanged, but the op still occupies DIV_CYCLES with busy asserted.
  - Signed A = most-negative, B = -1: LO = A, HI = 0.
- HIwrite/LOwrite:
  - Take effect at the next edge only when busy=0 and start=0.
  - Ignored while busy=1, since the hazard unit prevents that combination.
  - HIwrite and LOwrite may both be asserted in one cycle; both registers take A.
  - If start and HIwrite/LOwrite are asserted together, start wins and the write is dropped.
- Result arithmetic may be purely combinational at completion or iterative (shift-add / restoring division) over the latency. Only the latency and the final HI/LO values are architectural.

Test Plan:
- mult: A=0xFFFFFFFE (-2), B=3, default params. Required: busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy=0 at edge 5.
- divu then div:
  - divu A=7, B=2: after 10 cycles LO=3, HI=1.
  - div A=-7 (0xFFFFFFF9), B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Boundary divides:
  - div A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu with B=0 after mthi 0x11/mtlo 0x22: HI=0x11, LO=0x22 unchanged; busy still 10 cycles.
- Accumulate: mtlo 10, mthi 0, then maddu A=4, B=5: LO=30, HI=0. Then msub A=1, B=31: LO=0xFFFFFFFF, HI=0xFFFFFFFF.
- Protocol:
  - start while busy: ignored, HI/LO reflect only the first op.
  - HIwrite while busy: ignored.
  - start asserted at the completion edge: accepted, busy stays high continuously.
- Reset at cycle 3 of a mult: busy=0, HI=LO=0 immediately (asynchronous), no later update.
- Re-run the first scenario with MULT_CYCLES=1: busy for exactly 1 cycle. With WIDTH=16: A=0xFFFF, B=0xFFFF unsigned gives HI=0xFFFE, LO=0x0001.
